// File: rtl/uart_fifo_tx.sv
// Drains words from a show-ahead-less FIFO and sends each one as two 8N1 UART bytes,
// low byte first, high byte zero-extended.
module uart_fifo_tx #(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter int unsigned RD_DATA_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tx_en,
    input  logic                     rd_empty,
    input  logic [RD_DATA_WIDTH-1:0] rd_data,
    output logic                     rd_en,
    output logic                     tx,
    output logic                     busy,
    output logic [15:0]              word_cnt
);

    localparam logic [15:0] TmrLast = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StStart,
        StData,
        StStop
    } state_e;

    state_e                   state_q, state_d;
    logic [15:0]              tmr_q, tmr_d;
    logic [2:0]               bit_q, bit_d;
    logic                     byte_q, byte_d;
    logic [RD_DATA_WIDTH-1:0] word_q, word_d;
    logic [15:0]              word_cnt_q, word_cnt_d;
    logic [7:0]               byte0, byte1, cur_byte;
    logic                     tmr_done;

    always_comb begin
        byte0 = word_q[7:0];
        byte1 = '0;
        byte1[RD_DATA_WIDTH-9:0] = word_q[RD_DATA_WIDTH-1:8];
        cur_byte = byte_q ? byte1 : byte0;
    end

    assign tmr_done = (tmr_q == TmrLast);

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        word_d     = word_q;
        word_cnt_d = word_cnt_q;
        rd_en      = 1'b0;
        tx         = 1'b1;
        unique case (state_q)
            StIdle: begin
                tmr_d = '0;
                // rst gate keeps the strobe quiet while the async reset is held
                if (tx_en && !rd_empty && !rst) begin
                    rd_en   = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: state_d = StLatch;
            StLatch: begin
                word_d  = rd_data;
                byte_d  = 1'b0;
                bit_d   = '0;
                tmr_d   = '0;
                state_d = StStart;
            end
            StStart: begin
                tx = 1'b0;
                if (tmr_done) begin
                    tmr_d   = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            StData: begin
                tx = cur_byte[bit_q];
                if (tmr_done) begin
                    tmr_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            StStop: begin
                if (tmr_done) begin
                    tmr_d = '0;
                    if (!byte_q) begin
                        byte_d  = 1'b1;
                        state_d = StStart;
                    end else begin
                        word_cnt_d = word_cnt_q + 16'd1;
                        state_d    = StIdle;
                    end
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The fetch cycle itself counts as busy even though the FSM is still in idle
    assign busy     = (state_q != StIdle) || rd_en;
    assign word_cnt = word_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            tmr_q      <= '0;
            bit_q      <= '0;
            byte_q     <= 1'b0;
            word_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            word_q     <= word_d;
            word_cnt_q <= word_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Random and directed bench for uart_fifo_tx against a timeline model of each word's
// transmission measured from its read strobe.
module tb_uart_fifo_tx;

    localparam int CPB    = 4;
    localparam int W      = 12;
    localparam int LAST_T = 2 + 20 * CPB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tx_en = 1'b0;
    logic         rd_empty = 1'b1;
    logic [W-1:0] rd_data = '0;
    logic         rd_en, tx, busy;
    logic [15:0]  word_cnt;

    uart_fifo_tx #(.CLKS_PER_BIT(CPB), .RD_DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_en    (tx_en),
        .rd_empty (rd_empty),
        .rd_data  (rd_data),
        .rd_en    (rd_en),
        .tx       (tx),
        .busy     (busy),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    logic [W-1:0] fifo[$];
    logic [W-1:0] m_q[$];
    bit           m_active = 1'b0;
    int           m_t = 0;
    logic [W-1:0] m_word = '0;
    logic [15:0]  m_cnt = '0;
    logic         e_rd_en, e_busy, e_tx;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           rd_en_seen = 0;
    bit           cap_on = 1'b0;
    logic [2:0]   cap[$];

    function automatic logic exp_tx_at(input int t, input logic [W-1:0] w);
        int         idx, b, p;
        logic [15:0] wx;
        logic [7:0] by;
        if (t < 3) return 1'b1;
        idx = t - 3;
        b   = idx / (10 * CPB);
        p   = (idx % (10 * CPB)) / CPB;
        wx  = 16'(w);
        by  = (b == 0) ? wx[7:0] : wx[15:8];
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return by[p-1];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        fifo.push_back(w);
        m_q.push_back(w);
    endtask

    task automatic tick();
        logic pop;
        rd_empty = (fifo.size() == 0);
        @(negedge clk);
        if (rst) begin
            e_rd_en = 1'b0; e_busy = 1'b0; e_tx = 1'b1;
        end else if (!m_active) begin
            e_rd_en = tx_en && (m_q.size() > 0);
            e_busy  = e_rd_en;
            e_tx    = 1'b1;
        end else begin
            e_rd_en = 1'b0; e_busy = 1'b1; e_tx = exp_tx_at(m_t, m_word);
        end
        chk("rd_en", int'(rd_en), int'(e_rd_en));
        chk("busy", int'(busy), int'(e_busy));
        chk("tx", int'(tx), int'(e_tx));
        chk("word_cnt", int'(word_cnt), rst ? 0 : int'(m_cnt));
        if (rd_en) rd_en_seen++;
        if (cap_on) cap.push_back({busy, rd_en, tx});
        pop = rd_en;
        @(posedge clk);
        #1;
        if (pop) begin
            if (fifo.size() > 0) rd_data = fifo.pop_front();
            else chk("fifo_underflow", 1, 0);
        end
        if (rst) begin
            m_active = 1'b0;
            m_cnt    = '0;
        end else if (e_rd_en) begin
            m_word   = m_q.pop_front();
            m_active = 1'b1;
            m_t      = 1;
        end else if (m_active) begin
            if (m_t == LAST_T) begin
                m_active = 1'b0;
                m_cnt    = m_cnt + 16'd1;
            end else begin
                m_t++;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int pat[20] = '{0,0,0,1,1,1,0,1,0,1, 0,0,1,0,1,0,0,0,0,1};
        int i0, i1, busy_n, rst_hold, ix;

        // reset with enable high and nothing queued
        tx_en = 1'b1;
        run(3);
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rd_en", int'(rd_en), 0);
        chk("reset_word_cnt", int'(word_cnt), 0);
        rst = 1'b0;
        run(2);

        // single word 0xA5C, captured line checked against hand-written bit pattern
        cap_on = 1'b1;
        rd_en_seen = 0;
        push(12'hA5C);
        run(100);
        cap_on = 1'b0;
        i0 = -1; i1 = -1; busy_n = 0;
        for (int i = 0; i < cap.size(); i++) begin
            if (cap[i][2]) busy_n++;
            if (i0 < 0 && cap[i][1]) i0 = i;
            if (i0 >= 0 && i1 < 0 && !cap[i][0]) i1 = i;
        end
        chk("tx_fall_latency", i1 - i0, 3);
        for (int k = 0; k < 20; k++) begin
            ix = i1 + k * CPB + CPB / 2;
            if (i1 >= 0 && ix < cap.size()) chk("frame_bit", int'(cap[ix][0]), pat[k]);
            else chk("frame_bit_missing", ix, -1);
        end
        chk("single_busy_cycles", busy_n, 83);
        chk("single_rd_en_pulses", rd_en_seen, 1);
        chk("single_word_cnt", int'(word_cnt), 1);

        // three words back to back
        rd_en_seen = 0;
        push(12'h001); push(12'h7FF); push(12'hFFF);
        run(3 * 83 + 10);
        chk("burst_rd_en_pulses", rd_en_seen, 3);
        chk("burst_word_cnt", int'(word_cnt), 4);

        // empty FIFO with enable high
        rd_en_seen = 0;
        run(1000);
        chk("empty_rd_en_pulses", rd_en_seen, 0);
        chk("empty_busy", int'(busy), 0);

        // enable dropped in data bit 3 of byte 0
        rd_en_seen = 0;
        push(12'h123); push(12'h456);
        run(20);
        tx_en = 1'b0;
        run(200);
        chk("drop_en_rd_en_pulses", rd_en_seen, 1);
        chk("drop_en_word_cnt", int'(word_cnt), 5);
        chk("drop_en_fifo_left", fifo.size(), 1);

        // reset in stop bit of byte 0; word is lost, next one fetched afterwards
        tx_en = 1'b1;
        push(12'h789);
        run(40);
        rst = 1'b1;
        #1;
        chk("midrst_tx", int'(tx), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_word_cnt", int'(word_cnt), 0);
        run(2);
        rst = 1'b0;
        rd_en_seen = 0;
        run(200);
        chk("midrst_after_cnt", int'(word_cnt), 1);
        chk("midrst_after_pulses", rd_en_seen, 1);
        chk("midrst_fifo_left", fifo.size(), 0);

        // random traffic, enable toggling, rare resets
        rst_hold = 0;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 99) < 8 && fifo.size() < 4) push(W'($urandom_range(0, 4095)));
            if ($urandom_range(0, 49) == 0) tx_en = ~tx_en;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst = 1'b0;
            end else if ($urandom_range(0, 1499) == 0) begin
                rst = 1'b1;
                rst_hold = 2;
            end
            tick();
        end
        rst = 1'b0;

        // counter wrap from a preloaded 0xFFFF
        tx_en = 1'b0;
        run(200);
        fifo.delete();
        m_q.delete();
        dut.word_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        tick();
        chk("wrap_preload", int'(word_cnt), 16'hFFFF);
        tx_en = 1'b1;
        push(12'h3C3);
        run(90);
        chk("wrap_word_cnt", int'(word_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
